// File: rtl/divider.sv
// Multi-cycle restoring divider: one quotient bit per cycle, MSB first, IDLE/CALC/DONE control.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncating division, same latency).
module divider #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div0
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dq;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_part;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_div0;

  logic             w_accept;
  logic             w_last;
  logic             w_zero;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic [WIDTH-1:0] w_part_nxt;
  logic [WIDTH-1:0] w_dq_nxt;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;
  logic [WIDTH-1:0] w_quot_fin;
  logic [WIDTH-1:0] w_rem_fin;

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_zero   = (op2 == '0);

  // Partial remainder stays below the divisor, so the shifted value fits WIDTH+1 bits and
  // the top bit of the difference is the borrow.
  assign w_shift    = {r_part, r_dq[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_dvs};
  assign w_borrow   = w_diff[WIDTH];
  assign w_part_nxt = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_dq_nxt   = {r_dq[WIDTH-2:0], ~w_borrow};

`ifdef DIVIDER_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? ('0 - v) : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? ('0 - v) : v;
  endfunction

  assign w_mag1     = abs_val(op1);
  assign w_mag2     = abs_val(op2);
  assign w_quot_fin = cond_neg(w_dq_nxt, r_neg_q);
  assign w_rem_fin  = cond_neg(w_part_nxt, r_neg_r);

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_neg_q <= op1[WIDTH-1] ^ op2[WIDTH-1];
      r_neg_r <= op1[WIDTH-1];
    end
  end
`else
  assign w_mag1     = op1;
  assign w_mag2     = op2;
  assign w_quot_fin = w_dq_nxt;
  assign w_rem_fin  = w_part_nxt;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = w_zero ? DONE : CALC;
      CALC:    if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? (w_zero ? DONE : CALC) : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_div0  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt  <= '0;
        r_div0 <= w_zero;
        if (w_zero) begin
          r_quot <= '1;
          r_rem  <= op1;
        end
      end else if (r_state == CALC) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last) begin
          r_quot <= w_quot_fin;
          r_rem  <= w_rem_fin;
        end
      end
    end
  end

  // Working datapath; only meaningful between an accepted start and DONE.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_dq   <= w_mag1;
      r_dvs  <= w_mag2;
      r_part <= '0;
    end else if (r_state == CALC) begin
      r_dq   <= w_dq_nxt;
      r_part <= w_part_nxt;
    end
  end

  assign busy = (r_state == CALC);
  assign done = (r_state == DONE);
  assign quot = r_quot;
  assign rem  = r_rem;
  assign div0 = r_div0;

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: stimulus pushes expected results, a monitor pops on done.
module tb_divider;
  localparam int W = 18;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op1 = '0;
  logic [W-1:0] op2 = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         div0;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         d0;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_done   = 0;
  int   cyc      = 0;

  divider #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op1  (op1),
    .op2  (op2),
    .busy (busy),
    .done (done),
    .quot (quot),
    .rem  (rem),
    .div0 (div0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got quot=0x%0h rem=0x%0h, expected no result", quot, rem);
      end else begin
        e = sb.pop_front();
        chk("sb_quot", 32'(quot), 32'(e.q));
        chk("sb_rem", 32'(rem), 32'(e.r));
        chk("sb_div0", 32'(div0), 32'(e.d0));
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic d0);
    @(negedge clk);
    op1 = a;
    op2 = b;
    start = 1'b1;
    sb.push_back('{q: q, r: r, d0: d0});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int nb);
    lat = 0;
    nb  = 0;
    while (!done && lat < 60) begin
      if (busy) nb++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin : stim
    int   lat;
    int   nb;
    int   nd0;
    int   last;
    vec_t b2b[5];

    b2b[0] = '{a: 18'd1000,   b: 18'd10,     q: 18'd100,   r: 18'd0};
    b2b[1] = '{a: 18'd12345,  b: 18'd123,    q: 18'd100,   r: 18'd45};
    b2b[2] = '{a: 18'd7,      b: 18'd9,      q: 18'd0,     r: 18'd7};
    b2b[3] = '{a: 18'h3FFFF,  b: 18'h3FFFF,  q: 18'd1,     r: 18'd0};
    b2b[4] = '{a: 18'h1F3A7,  b: 18'd31,     q: 18'h0101E, r: 18'd5};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quot", 32'(quot), 32'd0);
    chk("rst_rem", 32'(rem), 32'd0);
    chk("rst_div0", 32'(div0), 32'd0);
    rst_n = 1'b1;

    issue(18'd100, 18'd7, 18'd14, 18'd2, 1'b0);
    wait_done(lat, nb);
    chk("lat_100_7", 32'(lat), 32'd18);
    chk("busy_cycles_100_7", 32'(nb), 32'd18);

    issue(18'd5, 18'd0, 18'h3FFFF, 18'd5, 1'b1);
    wait_done(lat, nb);
    chk("lat_div0", 32'(lat), 32'd0);
    chk("busy_div0", 32'(nb), 32'd0);
    repeat (4) @(negedge clk);
    chk("hold_quot_div0", 32'(quot), 32'h3FFFF);
    chk("hold_div0", 32'(div0), 32'd1);
    chk("done_one_cycle", 32'(done), 32'd0);

    nd0 = n_done;
    issue(18'h3FFFF, 18'd1, 18'h3FFFF, 18'd0, 1'b0);
    repeat (5) @(negedge clk);
    op1 = 18'd9;
    op2 = 18'd3;
    start = 1'b1;
    @(negedge clk);
    chk("busy_mid_start", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(lat, nb);
    chk("lat_mid_start", 32'(lat), 32'd12);
    repeat (25) @(negedge clk);
    chk("single_done", 32'(n_done - nd0), 32'd1);
    chk("hold_quot", 32'(quot), 32'h3FFFF);

`ifdef DIVIDER_SIGNED_EN
    issue(18'h3FFF9, 18'd2, 18'h3FFFD, 18'h3FFFF, 1'b0);
`else
    issue(18'h3FFF9, 18'd2, 18'h1FFFC, 18'd1, 1'b0);
`endif
    wait_done(lat, nb);
    chk("lat_neg7_2", 32'(lat), 32'd18);

`ifdef DIVIDER_SIGNED_EN
    issue(18'h20000, 18'h3FFFF, 18'h20000, 18'd0, 1'b0);
`else
    issue(18'h20000, 18'h3FFFF, 18'd0, 18'h20000, 1'b0);
`endif
    wait_done(lat, nb);

    issue(18'd100, 18'd7, 18'd14, 18'd2, 1'b0);
    repeat (6) @(negedge clk);
    chk("busy_before_rst", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_quot", 32'(quot), 32'd0);
    chk("midrst_rem", 32'(rem), 32'd0);
    chk("midrst_div0", 32'(div0), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(18'd20, 18'd6, 18'd3, 18'd2, 1'b0);
    wait_done(lat, nb);
    chk("lat_after_rst", 32'(lat), 32'd18);
    @(negedge clk);

    last = 0;
    for (int i = 0; i < 5; i++) begin
      op1 = b2b[i].a;
      op2 = b2b[i].b;
      start = 1'b1;
      sb.push_back('{q: b2b[i].q, r: b2b[i].r, d0: 1'b0});
      @(negedge clk);
      lat = 0;
      while (!done && lat < 60) begin
        @(negedge clk);
        lat++;
      end
      chk("b2b_lat", 32'(lat), 32'd18);
      if (i > 0) chk("b2b_period", 32'(cyc - last), 32'd19);
      last = cyc;
    end
    start = 1'b0;

    lat = 0;
    while (sb.size() != 0 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
